// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file bus arbiter: FSM encoding,
// default widths and a packed-vector slice helper.
`ifndef REGFILE_ARB_PKG_SV
`define REGFILE_ARB_PKG_SV

// Select element idx of width w from a flat packed vector.
`define RF_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package regfile_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;

    // State names the phase whose outputs are being launched into the
    // output registers: IDLE picks a grant, ACCESS launches the bus strobe,
    // RESP launches the response pulse.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

endpackage

`endif

// File: rtl/regfile_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward with wrap-around.
module regfile_bus_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx,
    output logic               any
);

    logic [IW-1:0] cand;

    // Walk the requesters starting at ptr; the first valid one wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = IW'((int'(ptr) + off) % NUM_REQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_bus_arbiter.sv
// Round-robin arbiter sharing one register-file slave bus among NUM_REQ
// requesters. Each accepted request runs accept -> bus access -> response,
// one transaction every three cycles, with all outputs registered.
module regfile_bus_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic                          chip_select,
    output logic                          write_en,
    output logic                          read_en,
    output logic [DATA_WIDTH-1:0]         write_data,
    input  logic [DATA_WIDTH-1:0]         read_data,
    input  logic                          data_valid
);

    localparam int            IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    arb_state_e state_q, state_d;

    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]         gnt_idx_q, gnt_idx_d;
    logic [NUM_REQ-1:0]    gnt_oh_q, gnt_oh_d;
    logic                  txn_write_q, txn_write_d;
    logic [ADDR_WIDTH-1:0] txn_addr_q, txn_addr_d;
    logic [DATA_WIDTH-1:0] txn_wdata_q, txn_wdata_d;

    logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  re_q, re_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [NUM_REQ-1:0]    pick_gnt;
    logic [IW-1:0]         pick_idx;
    logic                  pick_any;

    regfile_bus_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Next-state and next-output logic; every output defaults to 0 so
    // strobes and pulses last exactly one cycle.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_oh_d    = gnt_oh_q;
        txn_write_d = txn_write_q;
        txn_addr_d  = txn_addr_q;
        txn_wdata_d = txn_wdata_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        addr_d      = '0;
        cs_d        = 1'b0;
        we_d        = 1'b0;
        re_d        = 1'b0;
        wdata_d     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_idx_d   = pick_idx;
                    gnt_oh_d    = pick_gnt;
                    txn_write_d = req_write[pick_idx];
                    txn_addr_d  = `RF_SLICE(req_addr, pick_idx, ADDR_WIDTH);
                    txn_wdata_d = `RF_SLICE(req_wdata, pick_idx, DATA_WIDTH);
                    req_ready_d = pick_gnt;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cs_d    = 1'b1;
                we_d    = txn_write_q;
                re_d    = !txn_write_q;
                addr_d  = txn_addr_q;
                wdata_d = txn_write_q ? txn_wdata_q : '0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // The bus strobe is on the wire this cycle, so the slave's
                // combinational read data is sampled straight into the response.
                rsp_valid_d = gnt_oh_q;
                if (!txn_write_q) begin
                    if (data_valid) begin
                        rsp_rdata_d = read_data;
                    end else begin
                        rsp_err_d = 1'b1;
                    end
                end
                rr_ptr_d = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + IW'(1);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any transaction immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            gnt_idx_q   <= '0;
            gnt_oh_q    <= '0;
            txn_write_q <= 1'b0;
            txn_addr_q  <= '0;
            txn_wdata_q <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            addr_q      <= '0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_oh_q    <= gnt_oh_d;
            txn_write_q <= txn_write_d;
            txn_addr_q  <= txn_addr_d;
            txn_wdata_q <= txn_wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            addr_q      <= addr_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            re_q        <= re_d;
            wdata_q     <= wdata_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign addr        = addr_q;
    assign chip_select = cs_q;
    assign write_en    = we_q;
    assign read_en     = re_q;
    assign write_data  = wdata_q;

endmodule

// File: tb/tb_regfile_bus_arbiter.sv
// Self-checking bench for regfile_bus_arbiter: a transaction-timeline model
// predicts every output each cycle, plus directed literal checks.
module tb_regfile_bus_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid, req_ready, req_write, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]     rsp_rdata, write_data, read_data;
    logic              rsp_err, chip_select, write_en, read_en, data_valid;
    logic [AW-1:0]     addr;

    int errors = 0;
    int checks = 0;
    int ncyc   = 0;
    logic [NREQ-1:0] hold;

    typedef struct {int cyc; int idx;} ev_t;
    ev_t acc_log[$];
    ev_t rsp_log[$];

    always #5 clk = ~clk;

    regfile_bus_arbiter #(
        .NUM_REQ    (NREQ),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .addr        (addr),
        .chip_select (chip_select),
        .write_en    (write_en),
        .read_en     (read_en),
        .write_data  (write_data),
        .read_data   (read_data),
        .data_valid  (data_valid)
    );

    // Slave register file: combinational read pattern, 0x04 reads as 3.
    function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
        if (a == 8'h04) return 32'h0000_0003;
        return {8'hA5, 8'h00, a, ~a};
    endfunction

    assign read_data = slave_data(addr);

    // ---------------- timeline model ----------------
    // A transaction accepted so that ready shows in cycle t puts the bus
    // strobe in cycle t+1 and the response in t+2; the next grant can show
    // in t+3 at the earliest.
    logic [NREQ-1:0] e_ready, e_rsp;
    logic [DW-1:0]   e_rdata, e_wd;
    logic            e_err, e_cs, e_we, e_re;
    logic [AW-1:0]   e_addr;

    int            m_cyc, m_tacc;
    logic          m_active, m_wr;
    logic [1:0]    m_ptr, m_g;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    always @(posedge clk or negedge rst_n) begin : model
        int            k;
        logic          found;
        logic [1:0]    gi, cand;
        logic [NREQ-1:0] nr, nrsp;
        logic [DW-1:0] nrd, nwd;
        logic          nerr, ncs, nwe, nre;
        logic [AW-1:0] na;
        if (!rst_n) begin
            m_cyc <= 0; m_tacc <= 0; m_active <= 1'b0; m_wr <= 1'b0;
            m_ptr <= '0; m_g <= '0; m_addr <= '0; m_wdata <= '0;
            e_ready <= '0; e_rsp <= '0; e_rdata <= '0; e_wd <= '0;
            e_err <= 1'b0; e_cs <= 1'b0; e_we <= 1'b0; e_re <= 1'b0; e_addr <= '0;
        end else begin
            k = m_cyc + 1;
            nr = '0; nrsp = '0; nrd = '0; nwd = '0;
            nerr = 1'b0; ncs = 1'b0; nwe = 1'b0; nre = 1'b0; na = '0;
            found = 1'b0; gi = '0;
            if (!m_active) begin
                for (int j = 0; j < NREQ; j++) begin
                    cand = 2'((int'(m_ptr) + j) % NREQ);
                    if (!found && req_valid[cand]) begin
                        found = 1'b1;
                        gi = cand;
                    end
                end
                if (found) begin
                    nr[gi]   = 1'b1;
                    m_active <= 1'b1;
                    m_tacc   <= k;
                    m_g      <= gi;
                    m_wr     <= req_write[gi];
                    m_addr   <= req_addr[gi*AW +: AW];
                    m_wdata  <= req_wdata[gi*DW +: DW];
                    m_ptr    <= 2'((int'(gi) + 1) % NREQ);
                end
            end else if (k == m_tacc + 1) begin
                ncs = 1'b1;
                nwe = m_wr;
                nre = !m_wr;
                na  = m_addr;
                nwd = m_wr ? m_wdata : '0;
            end else if (k == m_tacc + 2) begin
                nrsp[m_g] = 1'b1;
                if (!m_wr) begin
                    if (data_valid) nrd = slave_data(m_addr);
                    else nerr = 1'b1;
                end
                m_active <= 1'b0;
            end
            m_cyc   <= k;
            e_ready <= nr;  e_rsp <= nrsp; e_rdata <= nrd; e_err <= nerr;
            e_cs    <= ncs; e_we  <= nwe;  e_re    <= nre; e_addr <= na; e_wd <= nwd;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    function automatic int oh2idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic compare_all();
        int gi;
        chk("req_ready",   DW'(req_ready),   DW'(e_ready));
        chk("rsp_valid",   DW'(rsp_valid),   DW'(e_rsp));
        chk("rsp_rdata",   rsp_rdata,        e_rdata);
        chk("rsp_err",     DW'(rsp_err),     DW'(e_err));
        chk("chip_select", DW'(chip_select), DW'(e_cs));
        chk("write_en",    DW'(write_en),    DW'(e_we));
        chk("read_en",     DW'(read_en),     DW'(e_re));
        chk("addr",        DW'(addr),        DW'(e_addr));
        chk("write_data",  write_data,       e_wd);
        chk("we_re_excl",  DW'(write_en & read_en), '0);
        gi = oh2idx(req_ready);
        if (gi >= 0) acc_log.push_back('{ncyc, gi});
        gi = oh2idx(rsp_valid);
        if (gi >= 0) begin
            rsp_log.push_back('{ncyc, gi});
            $display("txn cyc=%0d req=%0d rdata=%08h err=%0b", ncyc, gi, rsp_rdata, rsp_err);
        end
    endtask

    // One cycle: compare at the falling edge, then retire accepted one-shot requests.
    task automatic tick();
        @(negedge clk);
        ncyc++;
        compare_all();
        for (int i = 0; i < NREQ; i++)
            if (req_ready[i] && !hold[i]) req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    task automatic post(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        req_write[i]            = wr;
        req_addr[i*AW +: AW]    = a;
        req_wdata[i*DW +: DW]   = wd;
        req_valid[i]            = 1'b1;
    endtask

    task automatic expect_grant(input string name, input int want);
        int got;
        got = -1;
        for (int n = 0; n < 12 && got < 0; n++) begin
            tick();
            if (req_ready != '0) got = oh2idx(req_ready);
        end
        chk(name, DW'(got), DW'(want));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b1; req_valid = '0; req_write = '0; req_addr = '0;
        req_wdata = '0; data_valid = 1'b1; hold = '0;
        #1 rst_n = 1'b0;
        tick(); tick();
        chk("rst_ready", DW'(req_ready), '0);
        chk("rst_rsp",   DW'(rsp_valid), '0);
        chk("rst_cs",    DW'(chip_select), '0);

        // All four requesters hold valid from reset: order 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) post(i, 1'b0, AW'(8'h08 + i), '0);
        hold = '1;
        rst_n = 1'b1;
        for (int n = 0; n < 40 && acc_log.size() < 5; n++) tick();
        hold = '0;
        req_valid = '0;
        drain();
        chk("rr_acc_count", DW'(acc_log.size()), 32'd5);
        chk("rr_rsp_count", DW'(rsp_log.size()), 32'd5);
        if (acc_log.size() >= 5 && rsp_log.size() >= 5) begin
            chk("rr_order0", DW'(acc_log[0].idx), 32'd0);
            chk("rr_order1", DW'(acc_log[1].idx), 32'd1);
            chk("rr_order2", DW'(acc_log[2].idx), 32'd2);
            chk("rr_order3", DW'(acc_log[3].idx), 32'd3);
            chk("rr_order4", DW'(acc_log[4].idx), 32'd0);
            for (int k = 1; k < 5; k++)
                chk("rr_gap", DW'(acc_log[k].cyc - acc_log[k-1].cyc), 32'd3);
            for (int k = 0; k < 5; k++) begin
                chk("rr_rsp_lat", DW'(rsp_log[k].cyc - acc_log[k].cyc), 32'd2);
                chk("rr_rsp_idx", DW'(rsp_log[k].idx), DW'(acc_log[k].idx));
            end
        end

        // Write from requester 0: addr 0x00, data 0x5.
        post(0, 1'b1, 8'h00, 32'h5);
        expect_grant("t1_grant", 0);
        tick();
        chk("t1_cs",    DW'(chip_select), 32'd1);
        chk("t1_we",    DW'(write_en),    32'd1);
        chk("t1_addr",  DW'(addr),        32'h0);
        chk("t1_wdata", write_data,       32'h5);
        tick();
        chk("t1_rsp",   DW'(rsp_valid),   32'b0001);
        chk("t1_rdata", rsp_rdata,        32'h0);
        drain();

        // Read from requester 2 at 0x04, slave returns 3.
        post(2, 1'b0, 8'h04, '0);
        expect_grant("t2_grant", 2);
        tick();
        chk("t2_re",    DW'(read_en),  32'd1);
        chk("t2_we",    DW'(write_en), 32'd0);
        tick();
        chk("t2_rsp",   DW'(rsp_valid), 32'b0100);
        chk("t2_rdata", rsp_rdata,      32'h3);
        chk("t2_err",   DW'(rsp_err),   32'd0);
        drain();

        // Serve 1 so the pointer sits at 2, then requesters 1 and 3 together.
        post(1, 1'b1, 8'h10, 32'hAB);
        expect_grant("t4_pre", 1);
        drain();
        post(1, 1'b1, 8'h11, 32'hCD);
        post(3, 1'b0, 8'h20, '0);
        expect_grant("t4_first", 3);
        expect_grant("t4_second", 1);
        drain();

        // Read with data_valid low gives an error; the next read is clean.
        data_valid = 1'b0;
        post(0, 1'b0, 8'h30, '0);
        expect_grant("t5_grant", 0);
        tick(); tick();
        chk("t5_rsp",   DW'(rsp_valid), 32'b0001);
        chk("t5_err",   DW'(rsp_err),   32'd1);
        chk("t5_rdata", rsp_rdata,      32'h0);
        data_valid = 1'b1;
        drain();
        post(2, 1'b0, 8'h04, '0);
        expect_grant("t5b_grant", 2);
        tick(); tick();
        chk("t5b_err",   DW'(rsp_err), 32'd0);
        chk("t5b_rdata", rsp_rdata,    32'h3);
        drain();

        // Reset during the bus cycle of a write from requester 3.
        rsp_log.delete();
        post(3, 1'b1, 8'h40, 32'hDEAD);
        expect_grant("t6_grant", 3);
        tick();
        chk("t6_cs_before", DW'(chip_select), 32'd1);
        chk("t6_we_before", DW'(write_en),    32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_cs_async", DW'(chip_select), 32'd0);
        chk("t6_we_async", DW'(write_en),    32'd0);
        chk("t6_re_async", DW'(read_en),     32'd0);
        tick(); tick();
        chk("t6_no_rsp", DW'(rsp_log.size()), 32'd0);
        post(0, 1'b0, 8'h50, '0);
        post(3, 1'b0, 8'h60, '0);
        rst_n = 1'b1;
        expect_grant("t6_first", 0);
        expect_grant("t6_second", 3);
        drain();
        chk("t6_rsp_count", DW'(rsp_log.size()), 32'd2);
        if (rsp_log.size() >= 1) chk("t6_rsp0_idx", DW'(rsp_log[0].idx), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
